mcont_to_chnbuf_pages: RTL
==========================

Name: mcont_to_chnbuf_pages

Overview:
Multi-page channel buffer that sits directly upstream of the per-channel read register in the memory controller's write-to-DDR path. A channel producer writes 64-bit words sequentially into fixed-size pages. The controller reads a completed page through buf_rd_chn / buf_rdata_chn and then releases it with buf_done. The block provides page-level flow control (want_rq, wr_full) and sticky overrun/underrun error flags.

Parameters:
CHN_LATENCY, 0, extra read-data register stages (0..2); 0 means data is valid the cycle after buf_rd_chn.
PAGE_WORDS_LOG2, 8, log2 of 64-bit words per page (256 words).
NUM_PAGES_LOG2, 2, log2 of page count (4 pages).

Ports:
clk  in  1  clock; the only clock domain.
rst  in  1  reset; synchronous, active-high.
wr_en  in  1  channel write strobe.
wr_data  in  64  channel write data.
wr_full  out  1  all pages filled and not yet released.
buf_raddr_rst_chn  in  1  reset the controller read address to word 0 of the current read page.
buf_rd_chn  in  1  controller read strobe; address post-increments.
buf_rdata_chn  out  64  read data.
buf_done  in  1  controller finished the current read page; release it.
want_rq  out  1  at least one full page is waiting for the controller.
pages_full  out  NUM_PAGES_LOG2+1  number of completed, unreleased pages.
err_clr  in  1  clear the sticky error flags.
overrun  out  1  sticky: write dropped because the buffer was full.
underrun  out  1  sticky: read or buf_done issued with no full page.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): the following are all 0: wpage, waddr, rpage, raddr, pages_full, overrun, underrun, buf_rdata_chn, and all latency pipeline registers. Memory contents are not reset. Reset mid-page discards any partial page.
- Write side: wr_en && !wr_full writes mem[{wpage,waddr}] <= wr_data, then waddr++.
  - On the write to the last word (waddr == all ones), waddr wraps to 0, wpage++ (modulo the page count) and pages_full increments.
  - wr_en && wr_full: the word is dropped, pointers are unchanged, overrun <= 1.
- wr_full = (pages_full == 2**NUM_PAGES_LOG2); combinational from the register.
- want_rq = (pages_full != 0); combinational from the register.
- Read address:
  - buf_raddr_rst_chn sets raddr <= 0.
  - buf_rd_chn reads mem[{rpage,raddr}] and then raddr++. raddr wraps within the page; it never advances rpage.
  - buf_raddr_rst_chn and buf_rd_chn in the same cycle: the read uses the old raddr, and raddr becomes 0 (reset wins over increment).
- Read data: the RAM output register captures on buf_rd_chn. buf_rdata_chn is valid exactly 1+CHN_LATENCY cycles after buf_rd_chn. Each stage loads only when its valid bit is set; otherwise buf_rdata_chn holds its value.
- buf_done with pages_full != 0: rpage++ (modulo), pages_full decrements, raddr <= 0.
- buf_done with pages_full == 0: no pointer change, underrun <= 1.
- buf_rd_chn with pages_full == 0: the read is still performed (stale data) and underrun <= 1.
- Page completion and valid buf_done in the same cycle: pages_full is unchanged and both pointers advance.
- Page completion while wr_full is impossible, because writes are blocked.
- err_clr clears overrun and underrun. If a new error event occurs in the same cycle, the error sets the flag (set wins).
- pages_full is never below 0 or above 2**NUM_PAGES_LOG2. Pointer arithmetic is unsigned and wraps naturally at its width.

Decomposition:
- Shared package: PAGE_WORDS_LOG2 and NUM_PAGES_LOG2 defaults, a 64-bit data-width constant, and a page/word address-split helper.
- Natural sub-module: chnbuf_ram_sdp, a simple dual-port RAM (64-bit, 2**(PAGE_WORDS_LOG2+NUM_PAGES_LOG2) deep) with a registered read port and a read-enable.
- The parent block holds the pointers, counters, flags and CHN_LATENCY pipeline.

Test Plan:
1. Reset, then write 256 words with data = index → at the cycle after word 255: pages_full=1, want_rq=1. Then buf_raddr_rst_chn, then 256 buf_rd_chn → buf_rdata_chn = 0..255, each 1 cycle after its strobe (CHN_LATENCY=0). Repeat with CHN_LATENCY=2 → 3-cycle delay.
2. Write 1024 words with no reads → wr_full=1, pages_full=4. A 1025th wr_en sets overrun=1 and no pointer moves. Then buf_done → wr_full=0, pages_full=3.
3. Issue the last word of page 1 and a buf_done for page 0 in the same cycle → pages_full stays at 1. The next reads return page-1 data.
4. buf_done and buf_rd_chn with pages_full=0 → underrun=1 and pages_full stays 0. err_clr → underrun=0. err_clr in the same cycle as a new underrun event → underrun=1.
5. Assert rst after 100 words of a partial page → all outputs are 0. The next full 256-word page lands in page 0 and reads back correctly.
6. Continuous streaming: the producer writes at 1 word/cycle while the controller reads and releases pages → no overrun, no underrun, and data order is preserved across wpage/rpage wrap (more than 8 pages).

Source files
------------

// File: rtl/mcont_to_chnbuf_pages_pkg.sv
// Shared constants and address helper for the multi-page channel buffer.
package mcont_to_chnbuf_pages_pkg;
  localparam int DATA_W              = 64;
  localparam int PAGE_WORDS_LOG2_DEF = 8;
  localparam int NUM_PAGES_LOG2_DEF  = 2;

  // Flat RAM address: page number in the upper bits, word offset in the lower bits.
  function automatic int unsigned page_word_addr(input int unsigned page,
                                                 input int unsigned word,
                                                 input int unsigned word_bits);
    return (page << word_bits) | word;
  endfunction
endpackage

// File: rtl/mcont_to_chnbuf_pages_if.sv
// Channel-producer / controller signal bundle of the multi-page channel buffer.
interface mcont_to_chnbuf_pages_if
  import mcont_to_chnbuf_pages_pkg::*;
#(
  parameter int NUM_PAGES_LOG2 = NUM_PAGES_LOG2_DEF
) ();
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_full;
  logic                      buf_raddr_rst_chn;
  logic                      buf_rd_chn;
  logic [DATA_W-1:0]         buf_rdata_chn;
  logic                      buf_done;
  logic                      want_rq;
  logic [NUM_PAGES_LOG2:0]   pages_full;
  logic                      err_clr;
  logic                      overrun;
  logic                      underrun;

  modport slave (
    input  wr_en, wr_data, buf_raddr_rst_chn, buf_rd_chn, buf_done, err_clr,
    output wr_full, buf_rdata_chn, want_rq, pages_full, overrun, underrun
  );

  modport master (
    output wr_en, wr_data, buf_raddr_rst_chn, buf_rd_chn, buf_done, err_clr,
    input  wr_full, buf_rdata_chn, want_rq, pages_full, overrun, underrun
  );
endinterface

// File: rtl/mcont_to_chnbuf_pages_ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port with enable.
// The read register resets to zero; the array itself is never reset.
module chnbuf_ram_sdp
  import mcont_to_chnbuf_pages_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mcont_to_chnbuf_pages.sv
// Multi-page channel buffer: sequential page writes, controller page reads and releases,
// page-level flow control and sticky overrun/underrun flags.
module mcont_to_chnbuf_pages
  import mcont_to_chnbuf_pages_pkg::*;
#(
  parameter int CHN_LATENCY     = 0,
  parameter int PAGE_WORDS_LOG2 = PAGE_WORDS_LOG2_DEF,
  parameter int NUM_PAGES_LOG2  = NUM_PAGES_LOG2_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  mcont_to_chnbuf_pages_if.slave chn
);
  localparam int AW  = PAGE_WORDS_LOG2 + NUM_PAGES_LOG2;
  localparam int PFW = NUM_PAGES_LOG2 + 1;
  localparam logic [PFW-1:0] PAGES_MAX = PFW'(2 ** NUM_PAGES_LOG2);

  logic [NUM_PAGES_LOG2-1:0]  wpage_q, wpage_d, rpage_q, rpage_d;
  logic [PAGE_WORDS_LOG2-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [PFW-1:0]             pages_full_q, pages_full_d;
  logic                       overrun_q, overrun_d, underrun_q, underrun_d;
  logic                       wr_full, have_page, wr_acc, page_done, page_rel;
  logic [AW-1:0]              ram_waddr, ram_raddr;
  logic [DATA_W-1:0]          ram_rdata;

  assign wr_full   = (pages_full_q == PAGES_MAX);
  assign have_page = (pages_full_q != '0);
  assign wr_acc    = chn.wr_en && !wr_full;
  assign page_done = wr_acc && (&waddr_q);
  assign page_rel  = chn.buf_done && have_page;

  always_comb begin
    wpage_d      = wpage_q;
    waddr_d      = waddr_q;
    rpage_d      = rpage_q;
    raddr_d      = raddr_q;
    pages_full_d = pages_full_q;
    if (wr_acc) begin
      waddr_d = waddr_q + 1'b1;
      if (page_done) wpage_d = wpage_q + 1'b1;
    end
    if (page_rel) rpage_d = rpage_q + 1'b1;
    // Address reset beats the post-increment; the read itself still uses the old raddr.
    if (chn.buf_raddr_rst_chn || page_rel) raddr_d = '0;
    else if (chn.buf_rd_chn)               raddr_d = raddr_q + 1'b1;
    case ({page_done, page_rel})
      2'b10:   pages_full_d = pages_full_q + 1'b1;
      2'b01:   pages_full_d = pages_full_q - 1'b1;
      default: pages_full_d = pages_full_q;
    endcase
    overrun_d  = (chn.wr_en && wr_full) || (overrun_q && !chn.err_clr);
    underrun_d = ((chn.buf_done || chn.buf_rd_chn) && !have_page) || (underrun_q && !chn.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wpage_q      <= '0;
      waddr_q      <= '0;
      rpage_q      <= '0;
      raddr_q      <= '0;
      pages_full_q <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wpage_q      <= wpage_d;
      waddr_q      <= waddr_d;
      rpage_q      <= rpage_d;
      raddr_q      <= raddr_d;
      pages_full_q <= pages_full_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ram_waddr = AW'(page_word_addr(32'(wpage_q), 32'(waddr_q), PAGE_WORDS_LOG2));
  assign ram_raddr = AW'(page_word_addr(32'(rpage_q), 32'(raddr_q), PAGE_WORDS_LOG2));

  chnbuf_ram_sdp #(.ADDR_W(AW)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc),
    .waddr_i (ram_waddr),
    .wdata_i (chn.wr_data),
    .re_i    (chn.buf_rd_chn),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  if (CHN_LATENCY == 0) begin : g_lat0
    assign chn.buf_rdata_chn = ram_rdata;
  end else begin : g_lat
    // stg_vld_q[s] marks fresh data at the input of stage s this cycle.
    logic [CHN_LATENCY-1:0] stg_vld_q;
    logic [DATA_W-1:0]      stg_dat_q [CHN_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_vld_q <= '0;
        for (int s = 0; s < CHN_LATENCY; s++) stg_dat_q[s] <= '0;
      end else begin
        stg_vld_q[0] <= chn.buf_rd_chn;
        if (stg_vld_q[0]) stg_dat_q[0] <= ram_rdata;
        for (int s = 1; s < CHN_LATENCY; s++) begin
          stg_vld_q[s] <= stg_vld_q[s-1];
          if (stg_vld_q[s]) stg_dat_q[s] <= stg_dat_q[s-1];
        end
      end
    end

    assign chn.buf_rdata_chn = stg_dat_q[CHN_LATENCY-1];
  end

  assign chn.wr_full    = wr_full;
  assign chn.want_rq    = have_page;
  assign chn.pages_full = pages_full_q;
  assign chn.overrun    = overrun_q;
  assign chn.underrun   = underrun_q;
endmodule
